design_20_arb: RTL and testbench

//   Round-robin arbiter and sequencer that shares one design_20 datapath among N requesters.
//   - Accepts operand pairs (a,b) over per-requester valid/ready.
//   - Issues one operation at a time to the datapath with a one-cycle dp_start pulse.
//   - Waits for dp_valid, then returns dp_y tagged with the requester id over a valid/ready response port.
//   - A watchdog aborts operations whose dp_valid never arrives and flags them with rsp_err.

---
 rtl/design_20_arb.sv | 154 +++++++++++++++
 tb/tb_design_20_arb.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/design_20_arb.sv
// design_20_arb: round-robin arbiter that shares one design_20 datapath
// among N requesters, with a watchdog that aborts silent operations.
module design_20_arb #(
  parameter int W   = 8,
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1,
  parameter int TMO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic           dp_start,
  output logic [W-1:0]   dp_a,
  output logic [W-1:0]   dp_b,
  input  logic [W-1:0]   dp_y,
  input  logic           dp_valid,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [W-1:0]   rsp_y,
  output logic [IDW-1:0] rsp_id,
  output logic           rsp_err,
  output logic           busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t         r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [7:0]     r_timer;
  logic [W-1:0]   r_op_a;
  logic [W-1:0]   r_op_b;
  logic [W-1:0]   r_rsp_y;
  logic           r_start;
  logic           r_rsp_valid;
  logic           r_rsp_err;

  logic [N-1:0]   w_gnt;
  logic [IDW-1:0] w_gid;
  logic           w_hit;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_idx;
  logic [W-1:0]   w_av [N];
  logic [W-1:0]   w_bv [N];
  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [IDW-1:0] w_nxt;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_av[g] = req_a[g*W +: W];
    assign w_bv[g] = req_b[g*W +: W];
  end

  // Search ptr, ptr+1, ... wrapping at N; first pending port wins.
  always_comb begin
    w_gnt = '0;
    w_gid = '0;
    w_hit = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(N)) begin
        w_sum = w_sum - (IDW+1)'(N);
      end
      w_idx = w_sum[IDW-1:0];
      if (!w_hit && req_valid[w_idx]) begin
        w_hit        = 1'b1;
        w_gnt[w_idx] = 1'b1;
        w_gid        = w_idx;
      end
    end
  end

  assign w_a   = w_av[w_gid];
  assign w_b   = w_bv[w_gid];
  assign w_nxt = (r_id == IDW'(N-1)) ? '0 : r_id + 1'b1;

  assign req_ready =
    (r_state == S_IDLE && !rst) ? w_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_timer     <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_y     <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_op_a  <= w_a;
            r_op_b  <= w_b;
            r_id    <= w_gid;
            r_start <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dp_valid) begin
            r_rsp_y     <= dp_y;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_timer == 8'(TMO-1)) begin
            r_rsp_y     <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_ptr       <= w_nxt;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign dp_start  = r_start;
  assign dp_a      = r_op_a;
  assign dp_b      = r_op_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_y     = r_rsp_y;
  assign rsp_id    = r_id;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_design_20_arb.sv
// tb_design_20_arb: vector table, directed corner sequences and a
// randomized run checked against a transaction-timing model.
module tb_design_20_arb;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           dp_start;
  logic [W-1:0]   dp_a;
  logic [W-1:0]   dp_b;
  logic [W-1:0]   dp_y;
  logic           dp_valid;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_y;
  logic [IDW-1:0] rsp_id;
  logic           rsp_err;
  logic           busy;

  always #5 clk = ~clk;

  design_20_arb #(.W(W), .N(N), .IDW(IDW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
    .dp_y(dp_y), .dp_valid(dp_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct {
    logic [3:0] rv;
    logic [7:0] ab;
    logic [7:0] bb;
    int         k;
    logic [7:0] y;
    logic [3:0] gnt;
    int         id;
  } vec_t;

  vec_t       tbl [8];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] gq [$];
  int         ns, prev, cnt, bad;
  int         pend [N];
  logic [7:0] ra [N];
  logic [7:0] rb [N];
  bit         infl;
  int         tg, kp, rc, cid, nops, mptr, endw, w, r;
  logic [7:0] ca, cb, cy;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] ab, input logic [7:0] bb);
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = ab + 8'(i);
      req_b[i*W +: W] = bb + 8'(i);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dp"}, {dp_start, dp_a, dp_b, busy}, 0);
    chk({tag, "_rsp"}, {req_ready, rsp_valid, rsp_y, rsp_id, rsp_err}, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    dp_valid = 1'b0;
    rsp_ready = 1'b0;
    dp_y = '0;
    set_ops(8'h00, 8'h00);
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    logic [7:0] ea, eb;
    ea = v.ab + 8'(v.id);
    eb = v.bb + 8'(v.id);
    set_ops(v.ab, v.bb);
    req_valid = v.rv;
    #1;
    chk("grant", req_ready, v.gnt);
    step();
    chk("gnt_once", req_ready, 0);
    req_valid = '0;
    chk("start", {dp_start, busy}, 2'b11);
    chk("dp_ab", {dp_a, dp_b}, {ea, eb});
    step();
    chk("one_start", dp_start, 0);
    repeat (v.k) step();
    dp_y = v.y;
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    chk("rsp", {rsp_valid, rsp_err, rsp_id, rsp_y},
        {1'b1, 1'b0, 2'(v.id), v.y});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("idle", {busy, rsp_valid}, 0);
  endtask

  initial begin
    // Grant order follows ptr = last id + 1, starting from 0.
    tbl[0] = '{4'b0100, 8'h01, 8'h03, 1, 8'h08, 4'b0100, 2};
    tbl[1] = '{4'b0011, 8'h10, 8'h20, 0, 8'h30, 4'b0001, 0};
    tbl[2] = '{4'b1001, 8'h40, 8'h50, 3, 8'hA5, 4'b1000, 3};
    tbl[3] = '{4'b1110, 8'h60, 8'h70, 2, 8'h3C, 4'b0010, 1};
    tbl[4] = '{4'b0010, 8'h80, 8'h90, 5, 8'hFF, 4'b0010, 1};
    tbl[5] = '{4'b1111, 8'hA0, 8'hB0, 0, 8'h00, 4'b0100, 2};
    tbl[6] = '{4'b0111, 8'hC0, 8'hD0, 4, 8'h81, 4'b0001, 0};
    tbl[7] = '{4'b0101, 8'hE0, 8'h05, 7, 8'h77, 4'b0100, 2};

    do_reset();
    for (int i = 0; i < 8; i++) run_op(tbl[i]);

    // Round robin with all ports requesting.
    do_reset();
    set_ops(8'h01, 8'h02);
    req_valid = '1;
    rsp_ready = 1'b1;
    ns = 0;
    prev = 0;
    for (int c = 0; c < 20; c++) begin
      dp_valid = prev[0];
      dp_y = 8'h42;
      #1;
      if (req_ready != 0) gq.push_back(req_ready);
      if (dp_start) ns++;
      prev = int'(dp_start);
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    dp_valid = 1'b0;
    chk("rr_cnt", gq.size(), 5);
    chk("rr_starts", ns, 5);
    chk("rr_idle", busy, 0);
    for (int i = 0; i < gq.size() && i < 5; i++) begin
      chk("rr_order", gq[i], 4'b0001 << (i % 4));
    end

    // Watchdog timeout, then a late stray pulse.
    set_ops(8'h11, 8'h22);
    req_valid = 4'b0010;
    #1;
    chk("tmo_grant", req_ready, 4'b0010);
    step();
    req_valid = '0;
    chk("tmo_start", dp_start, 1);
    dp_y = 8'hAA;
    cnt = 0;
    while (cnt < 40) begin
      step();
      cnt++;
      if (rsp_valid) break;
    end
    chk("tmo_lat", cnt, TMO + 1);
    chk("tmo_rsp", {rsp_valid, rsp_err, rsp_id, rsp_y},
        {1'b1, 1'b1, 2'd1, 8'h00});
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    bad = 0;
    repeat (4) begin
      if (rsp_valid || busy) bad++;
      step();
    end
    chk("tmo_stray", bad, 0);

    // Response held under back-pressure.
    set_ops(8'h30, 8'h40);
    req_valid = 4'b1000;
    #1;
    chk("bp_grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    step();
    dp_y = 8'h5A;
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    req_valid = 4'b1111;
    #1;
    for (int c = 0; c < 10; c++) begin
      chk("bp_hold", {rsp_valid, rsp_id, rsp_y, rsp_err},
          {1'b1, 2'd3, 8'h5A, 1'b0});
      chk("bp_quiet", {req_ready, dp_start}, 0);
      step();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    step();
    rsp_ready = 1'b0;

    // Reset during WAIT discards the operation.
    set_ops(8'h50, 8'h60);
    req_valid = 4'b0100;
    #1;
    chk("rw_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    chk_zero("rw");
    rst = 1'b0;
    dp_y = 8'h99;
    dp_valid = 1'b1;
    step();
    dp_valid = 1'b0;
    bad = 0;
    repeat (3) begin
      if (rsp_valid || busy) bad++;
      step();
    end
    chk("rw_norsp", bad, 0);
    run_op('{4'b1111, 8'h07, 8'h09, 2, 8'h10, 4'b0001, 0});

    // ptr=1: port 0 dropped, port 3 still valid.
    run_op('{4'b1000, 8'h21, 8'h31, 1, 8'h66, 4'b1000, 3});
    bad = 0;
    repeat (4) begin
      if (rsp_valid || busy) bad++;
      step();
    end
    chk("drop_norsp", bad, 0);

    // Randomized traffic against the timing model.
    do_reset();
    mptr = 0;
    infl = 1'b0;
    nops = 0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pend[i] == 0 && $urandom_range(3) == 0) begin
          pend[i] = 1;
          ra[i] = 8'($urandom);
          rb[i] = 8'($urandom);
        end else if (pend[i] != 0 && $urandom_range(15) == 0) begin
          pend[i] = 0;
        end
        req_valid[i] = (pend[i] != 0);
        req_a[i*W +: W] = ra[i];
        req_b[i*W +: W] = rb[i];
      end
      rsp_ready = ($urandom_range(3) != 0);
      dp_valid = 1'b0;
      dp_y = 8'($urandom);
      endw = -1;
      if (infl) endw = (kp < TMO) ? tg + 2 + kp : tg + 1 + TMO;
      if (infl && kp < TMO && c == tg + 2 + kp) begin
        dp_valid = 1'b1;
        dp_y = cy;
      end else if (!(infl && c >= tg + 2 && c <= endw) &&
                   $urandom_range(7) == 0) begin
        dp_valid = 1'b1;
      end
      #1;
      if (!infl) begin
        w = -1;
        for (int j = 0; j < N; j++) begin
          if (w < 0 && req_valid[(mptr + j) % N]) w = (mptr + j) % N;
        end
        chk("r_grant", req_ready, (w < 0) ? 0 : (1 << w));
        chk("r_idle", {busy, dp_start, rsp_valid}, 0);
        if (w >= 0) begin
          infl = 1'b1;
          tg = c;
          cid = w;
          ca = ra[w];
          cb = rb[w];
          pend[w] = 0;
          r = int'($urandom_range(9));
          kp = (r < 7) ? r : ((r == 7) ? TMO - 1 : TMO);
          cy = 8'($urandom);
          rc = (kp < TMO) ? tg + 3 + kp : tg + 2 + TMO;
        end
      end else begin
        chk("r_busy", {busy, req_ready}, {1'b1, 4'b0000});
        chk("r_start", dp_start, (c == tg + 1));
        if (c > tg) chk("r_dpab", {dp_a, dp_b}, {ca, cb});
        chk("r_rv", rsp_valid, (c >= rc));
        if (c >= rc) begin
          chk("r_rsp", {rsp_id, rsp_err, rsp_y},
              (kp < TMO) ? {2'(cid), 1'b0, cy} : {2'(cid), 1'b1, 8'h00});
          if (rsp_ready) begin
            infl = 1'b0;
            mptr = (cid + 1) % N;
            nops++;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    chk("r_ops", (nops > 50), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
